// File: rtl/ifmap_row_packer.sv
// Frames a valid/ready pixel stream into tagged rows for the PE IFmap buffer.
// Each buffer word is {start_tag, end_tag, zero pad, pixel}; done pulses once per frame.
module ifmap_row_packer #(
  parameter int DATA_WIDTH = 6,
  parameter int BUF_WIDTH  = 8,
  parameter int LEN_WIDTH  = 5,
  parameter int ROWS_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  row_len,
  input  logic [ROWS_WIDTH-1:0] num_rows,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  src_ready,
  input  logic                  buf_full,
  output logic                  buf_wen,
  output logic [BUF_WIDTH-1:0]  buf_din,
  output logic                  busy,
  output logic                  done,
  output logic                  err_cfg,
  output logic [ROWS_WIDTH-1:0] row_count
);

  // state  | meaning
  // IDLE   | waiting for a valid start; cfg errors reported from here
  // STREAM | accepting pixels and writing tagged words into the buffer
  // FIN    | one-cycle done pulse, then back to IDLE
  typedef enum logic [1:0] {IDLE, STREAM, FIN} state_t;

  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = 1;
  localparam logic [ROWS_WIDTH-1:0] ROWS_ONE = 1;

  state_t                state;
  logic [LEN_WIDTH-1:0]  col;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [ROWS_WIDTH-1:0] rows_q;
  logic [ROWS_WIDTH-1:0] row_count_q;
  logic                  err_q;
  logic                  xfer;
  logic                  last_col;
  logic                  last_row;

  assign src_ready = (state == STREAM) && !buf_full;
  assign xfer      = src_valid && src_ready;
  assign buf_wen   = xfer;
  assign last_col  = (col == len_q - LEN_ONE);
  assign last_row  = (row_count_q == rows_q - ROWS_ONE);
  assign busy      = (state == STREAM);
  assign done      = (state == FIN);
  assign err_cfg   = err_q;
  assign row_count = row_count_q;

  // Word is only driven while a transfer happens so the bus idles at zero.
  always_comb begin
    buf_din = '0;
    if (xfer) begin
      buf_din[DATA_WIDTH-1:0] = src_data;
      buf_din[BUF_WIDTH-1]    = (col == '0);
      buf_din[BUF_WIDTH-2]    = last_col;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      col         <= '0;
      row_count_q <= '0;
      len_q       <= '0;
      rows_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if ((row_len != '0) && (num_rows != '0)) begin
              len_q       <= row_len;
              rows_q      <= num_rows;
              col         <= '0;
              row_count_q <= '0;
              state       <= STREAM;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (xfer) begin
            if (last_col) begin
              col         <= '0;
              row_count_q <= row_count_q + ROWS_ONE;
              if (last_row) state <= FIN;
            end else begin
              col <= col + LEN_ONE;
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifmap_row_packer.sv
// Directed bench for ifmap_row_packer: cycle vector table plus hand sequences
// for reset mid-frame and start-while-streaming.
module tb_ifmap_row_packer;

  logic       clk = 1'b0;
  logic       rst, start, src_valid, src_ready, buf_full, buf_wen;
  logic       busy, done, err_cfg;
  logic [4:0] row_len;
  logic [7:0] num_rows, row_count, buf_din;
  logic [5:0] src_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ifmap_row_packer dut (
    .clk(clk), .rst(rst), .start(start), .row_len(row_len), .num_rows(num_rows),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .buf_full(buf_full), .buf_wen(buf_wen), .buf_din(buf_din), .busy(busy),
    .done(done), .err_cfg(err_cfg), .row_count(row_count)
  );

  typedef struct {
    logic       start;
    logic [4:0] len;
    logic [7:0] rows;
    logic       valid;
    logic [5:0] data;
    logic       full;
    logic       e_ready;
    logic       e_wen;
    logic [7:0] e_din;
    logic       e_busy;
    logic       e_done;
    logic       e_err;
    logic [7:0] e_rc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic [4:0] ln, input logic [7:0] rw,
                     input logic vl, input logic [5:0] dt, input logic fl,
                     input logic rdy, input logic wen, input logic [7:0] din,
                     input logic bs, input logic dn, input logic er, input logic [7:0] rc);
    vec_t v;
    v = '{st, ln, rw, vl, dt, fl, rdy, wen, din, bs, dn, er, rc};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; row_len = 0; num_rows = 0; src_valid = 0; src_data = 0; buf_full = 0;
  endtask

  int n_wr, n_done, end_mask, idx;

  initial begin
    rst = 1;
    idle_inputs();
    step();
    step();
    rst = 0;
    @(negedge clk);
    check("rst_ready", src_ready, 0);
    check("rst_wen", buf_wen, 0);
    check("rst_din", buf_din, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_cfg, 0);
    check("rst_rc", row_count, 0);
    step();

    // T1: row_len=4, num_rows=2, pixels 1..8
    add(1, 4, 2, 0, 0, 0,  0, 0, 8'h00, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 0,  1, 1, 8'h81, 1, 0, 0, 0);
    add(0, 0, 0, 1, 2, 0,  1, 1, 8'h02, 1, 0, 0, 0);
    add(0, 0, 0, 1, 3, 0,  1, 1, 8'h03, 1, 0, 0, 0);
    add(0, 0, 0, 1, 4, 0,  1, 1, 8'h44, 1, 0, 0, 0);
    add(0, 0, 0, 1, 5, 0,  1, 1, 8'h85, 1, 0, 0, 1);
    add(0, 0, 0, 1, 6, 0,  1, 1, 8'h06, 1, 0, 0, 1);
    add(0, 0, 0, 1, 7, 0,  1, 1, 8'h07, 1, 0, 0, 1);
    add(0, 0, 0, 1, 8, 0,  1, 1, 8'h48, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 0, 1, 0, 2);
    add(0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 0, 0, 0, 2);
    // T2: row_len=1, num_rows=3
    add(1, 1, 3, 0, 0, 0,  0, 0, 8'h00, 0, 0, 0, 2);
    add(0, 0, 0, 1, 6'h3F, 0, 1, 1, 8'hFF, 1, 0, 0, 0);
    add(0, 0, 0, 1, 6'h00, 0, 1, 1, 8'hC0, 1, 0, 0, 1);
    add(0, 0, 0, 1, 6'h15, 0, 1, 1, 8'hD5, 1, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 0, 1, 0, 3);
    add(0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 0, 0, 0, 3);
    // T3: row_len=3, num_rows=1, buf_full for 3 cycles on the 2nd element
    add(1, 3, 1, 0, 0, 0,  0, 0, 8'h00, 0, 0, 0, 3);
    add(0, 0, 0, 1, 6'h0A, 0, 1, 1, 8'h8A, 1, 0, 0, 0);
    add(0, 0, 0, 1, 6'h0B, 1, 0, 0, 8'h00, 1, 0, 0, 0);
    add(0, 0, 0, 1, 6'h0B, 1, 0, 0, 8'h00, 1, 0, 0, 0);
    add(0, 0, 0, 1, 6'h0B, 1, 0, 0, 8'h00, 1, 0, 0, 0);
    add(0, 0, 0, 1, 6'h0B, 0, 1, 1, 8'h0B, 1, 0, 0, 0);
    add(0, 0, 0, 1, 6'h0C, 0, 1, 1, 8'h4C, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 0, 0, 0, 1);
    // T4: bad configs
    add(1, 0, 5, 0, 0, 0,  0, 0, 8'h00, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 0, 0, 1, 1);
    add(1, 3, 0, 0, 0, 0,  0, 0, 8'h00, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 0, 0, 1, 1);
    add(0, 0, 0, 1, 5, 0,  0, 0, 8'h00, 0, 0, 0, 1);

    foreach (vecs[i]) begin
      start = vecs[i].start; row_len = vecs[i].len; num_rows = vecs[i].rows;
      src_valid = vecs[i].valid; src_data = vecs[i].data; buf_full = vecs[i].full;
      @(negedge clk);
      check($sformatf("v%0d_ready", i), src_ready, vecs[i].e_ready);
      check($sformatf("v%0d_wen", i), buf_wen, vecs[i].e_wen);
      check($sformatf("v%0d_din", i), buf_din, vecs[i].e_din);
      check($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
      check($sformatf("v%0d_done", i), done, vecs[i].e_done);
      check($sformatf("v%0d_err", i), err_cfg, vecs[i].e_err);
      check($sformatf("v%0d_rc", i), row_count, vecs[i].e_rc);
      step();
    end
    idle_inputs();

    // T5: reset mid-frame after 6 writes, then a fresh 2x1 frame
    start = 1; row_len = 4; num_rows = 4;
    step();
    start = 0;
    n_wr = 0;
    for (int k = 0; k < 6; k++) begin
      src_valid = 1; src_data = 6'(k + 1);
      @(negedge clk);
      if (buf_wen) n_wr++;
      step();
    end
    check("t5_writes", n_wr, 6);
    src_valid = 0; rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    check("t5_busy", busy, 0);
    check("t5_rc", row_count, 0);
    check("t5_done", done, 0);
    check("t5_ready", src_ready, 0);
    step();
    @(negedge clk);
    check("t5_done2", done, 0);
    start = 1; row_len = 2; num_rows = 1;
    step();
    start = 0; src_valid = 1; src_data = 6'h11;
    @(negedge clk);
    check("t5_din0", buf_din, 8'h91);
    step();
    src_data = 6'h12;
    @(negedge clk);
    check("t5_din1", buf_din, 8'h52);
    step();
    src_valid = 0;
    @(negedge clk);
    check("t5_done_end", done, 1);
    step();

    // T6: start during STREAM is ignored
    start = 1; row_len = 3; num_rows = 2;
    step();
    start = 0;
    n_wr = 0; n_done = 0; end_mask = 0;
    for (int k = 0; k < 30; k++) begin
      src_valid = 1; src_data = 6'(k + 1);
      if (k == 2) begin
        start = 1; row_len = 7; num_rows = 9;
      end else begin
        start = 0;
      end
      @(negedge clk);
      if (buf_wen) begin
        if (buf_din[6]) end_mask |= (1 << n_wr);
        n_wr++;
      end
      if (done) n_done++;
      step();
    end
    idle_inputs();
    @(negedge clk);
    check("t6_writes", n_wr, 6);
    check("t6_end_tags", end_mask, 6'b100100);
    check("t6_dones", n_done, 1);
    check("t6_rc", row_count, 2);
    check("t6_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
